// File: rtl/mac_pkg.sv
// Shared definitions for the MAC controller and the MAC datapath.
// Holds the 2-bit op code type, the op-code constants and the default widths.
package mac_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_NOP = 2'b00;
  localparam op_t OP_MUL = 2'b01;
  localparam op_t OP_MAC = 2'b10;
  localparam op_t OP_CLR = 2'b11;

  localparam int unsigned MacWDefault    = 8;
  localparam int unsigned MacAccWDefault = 20;
  localparam int unsigned MacCntWDefault = 8;

endpackage

// File: rtl/mac_datapath_if.sv
// Controller <-> MAC datapath bundle.
//   ctrl_valid, ctrl, a, b : op request from the controller (sampled when ctrl_valid=1)
//   acc, acc_valid         : accumulator value and one-cycle update strobe
//   ovf, mac_cnt           : sticky overflow flag and saturating MUL/MAC count
// master = controller side, slave = datapath side.
interface mac_datapath_if
  import mac_pkg::*;
#(
  parameter int unsigned W     = MacWDefault,
  parameter int unsigned ACC_W = MacAccWDefault,
  parameter int unsigned CNT_W = MacCntWDefault
);

  logic                    ctrl_valid;
  op_t                     ctrl;
  logic signed [W-1:0]     a;
  logic signed [W-1:0]     b;
  logic signed [ACC_W-1:0] acc;
  logic                    acc_valid;
  logic                    ovf;
  logic [CNT_W-1:0]        mac_cnt;

  modport master (
    output ctrl_valid, ctrl, a, b,
    input  acc, acc_valid, ovf, mac_cnt
  );

  modport slave (
    input  ctrl_valid, ctrl, a, b,
    output acc, acc_valid, ovf, mac_cnt
  );

endinterface

// File: rtl/mac_mul_stage.sv
// Stage 1 of the MAC datapath: registered signed multiplier with valid/op passthrough.
//   clk, rst          : clock, asynchronous active-high reset
//   valid_i, op_i     : request strobe and op code
//   a_i, b_i          : signed operands
//   valid_o, op_o     : registered strobe and op code
//   prod_o            : registered full-width signed product a_i*b_i
module mac_mul_stage
  import mac_pkg::*;
#(
  parameter int unsigned W = MacWDefault
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  op_t                   op_i,
  input  logic signed [W-1:0]   a_i,
  input  logic signed [W-1:0]   b_i,
  output logic                  valid_o,
  output op_t                   op_o,
  output logic signed [2*W-1:0] prod_o
);

  logic                  valid_q;
  op_t                   op_q;
  logic signed [2*W-1:0] prod_q;
  logic signed [2*W-1:0] prod_d;

  // Operands are sign-extended to the product width before multiplying.
  always_comb begin
    prod_d = (2*W)'(a_i) * (2*W)'(b_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= OP_NOP;
      prod_q  <= '0;
    end else begin
      valid_q <= valid_i;
      // Op and operands are only captured under valid; the controller floats ctrl otherwise.
      if (valid_i) begin
        op_q   <= op_i;
        prod_q <= prod_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign op_o    = op_q;
  assign prod_o  = prod_q;

endmodule

// File: rtl/mac_datapath.sv
// Two-stage pipelined signed multiply-accumulate datapath.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mac_datapath_if.slave (ctrl_valid/ctrl/a/b in; acc/acc_valid/ovf/mac_cnt out)
// Stage 1 (mac_mul_stage) registers op and product; stage 2 (here) updates the accumulator.
// Build option MAC_DATAPATH_SAT_EN: clamp acc on MAC overflow instead of wrapping.
module mac_datapath
  import mac_pkg::*;
#(
  parameter int unsigned W     = MacWDefault,
  parameter int unsigned ACC_W = MacAccWDefault,
  parameter int unsigned CNT_W = MacCntWDefault
) (
  input logic           clk,
  input logic           rst,
  mac_datapath_if.slave bus
);

`ifdef MAC_DATAPATH_SAT_EN
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic                    s1_vld;
  op_t                     s1_op;
  logic signed [2*W-1:0]   s1_prod;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    acc_valid_q, acc_valid_d;
  logic                    ovf_q, ovf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic signed [ACC_W-1:0] p_ext;
  logic [ACC_W:0]          sum;
  logic                    mac_ovf;
  logic                    cnt_inc;

  mac_mul_stage #(
    .W(W)
  ) u_mul_stage (
    .clk     (clk),
    .rst     (rst),
    .valid_i (bus.ctrl_valid),
    .op_i    (bus.ctrl),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .valid_o (s1_vld),
    .op_o    (s1_op),
    .prod_o  (s1_prod)
  );

  always_comb begin
    p_ext = ACC_W'(s1_prod);
    // One guard bit: the top two bits of the sum differ exactly on signed overflow.
    sum     = {acc_q[ACC_W-1], acc_q} + {p_ext[ACC_W-1], p_ext};
    mac_ovf = sum[ACC_W] ^ sum[ACC_W-1];

    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    acc_valid_d = 1'b0;
    cnt_inc     = 1'b0;

    if (s1_vld) begin
      unique case (s1_op)
        OP_MUL: begin
          acc_d       = p_ext;
          acc_valid_d = 1'b1;
          cnt_inc     = 1'b1;
        end
        OP_MAC: begin
          acc_d       = sum[ACC_W-1:0];
          acc_valid_d = 1'b1;
          cnt_inc     = 1'b1;
          if (mac_ovf) begin
            ovf_d = 1'b1;
`ifdef MAC_DATAPATH_SAT_EN
            // sum[ACC_W] is the true sign of the unbounded result.
            acc_d = sum[ACC_W] ? AccMin : AccMax;
`endif
          end
        end
        OP_CLR: begin
          acc_d       = '0;
          ovf_d       = 1'b0;
          cnt_d       = '0;
          acc_valid_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (cnt_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      acc_valid_q <= acc_valid_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.acc       = acc_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.mac_cnt   = cnt_q;

endmodule

// File: tb/tb_mac_datapath.sv
// Directed self-checking bench for mac_datapath.
// dut_a uses the default widths; dut_b uses ACC_W=16 for the overflow/saturation corner.
module tb_mac_datapath;
  import mac_pkg::*;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  mac_datapath_if #(.W(8), .ACC_W(20), .CNT_W(8)) ifa ();
  mac_datapath_if #(.W(8), .ACC_W(16), .CNT_W(8)) ifb ();

  mac_datapath #(.W(8), .ACC_W(20), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  mac_datapath #(.W(8), .ACC_W(16), .CNT_W(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input op_t op, input logic signed [7:0] av,
                         input logic signed [7:0] bv);
    ifa.ctrl_valid = v;
    ifa.ctrl       = op;
    ifa.a          = av;
    ifa.b          = bv;
  endtask

  task automatic drive_b(input logic v, input op_t op, input logic signed [7:0] av,
                         input logic signed [7:0] bv);
    ifb.ctrl_valid = v;
    ifb.ctrl       = op;
    ifb.a          = av;
    ifb.b          = bv;
  endtask

  initial begin
    drive_a(1'b0, OP_NOP, 8'sd0, 8'sd0);
    drive_b(1'b0, OP_NOP, 8'sd0, 8'sd0);
    rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    tick();
    chk("rst_acc", ifa.acc, 0);
    chk("rst_valid", ifa.acc_valid, 0);
    chk("rst_ovf", ifa.ovf, 0);
    chk("rst_cnt", ifa.mac_cnt, 0);
    rst = 1'b0;
    tick();

    // Back-to-back MUL 2*3, MAC 4*5.
    drive_a(1'b1, OP_MUL, 8'sd2, 8'sd3);
    tick();
    chk("b2b_lat_valid", ifa.acc_valid, 0);
    drive_a(1'b1, OP_MAC, 8'sd4, 8'sd5);
    tick();
    drive_a(1'b0, OP_NOP, 8'sd0, 8'sd0);
    chk("b2b_mul_acc", ifa.acc, 6);
    chk("b2b_mul_valid", ifa.acc_valid, 1);
    tick();
    chk("b2b_mac_acc", ifa.acc, 26);
    chk("b2b_mac_valid", ifa.acc_valid, 1);
    chk("b2b_cnt", ifa.mac_cnt, 2);
    tick();
    chk("b2b_valid_drop", ifa.acc_valid, 0);

    // MUL 3*4 then idle: two-edge latency, single-cycle strobe.
    drive_a(1'b1, OP_MUL, 8'sd3, 8'sd4);
    tick();
    drive_a(1'b0, OP_NOP, 8'sd0, 8'sd0);
    chk("mul_lat_acc", ifa.acc, 26);
    chk("mul_lat_valid", ifa.acc_valid, 0);
    tick();
    chk("mul_acc", ifa.acc, 12);
    chk("mul_valid", ifa.acc_valid, 1);
    chk("mul_cnt", ifa.mac_cnt, 3);
    tick();
    chk("mul_valid_drop", ifa.acc_valid, 0);
    chk("mul_acc_hold", ifa.acc, 12);

    // MAC -2*5 onto 12.
    drive_a(1'b1, OP_MAC, -8'sd2, 8'sd5);
    tick();
    drive_a(1'b0, OP_NOP, 8'sd0, 8'sd0);
    tick();
    chk("mac_neg_acc", ifa.acc, 2);
    chk("mac_neg_cnt", ifa.mac_cnt, 4);
    chk("mac_neg_ovf", ifa.ovf, 0);

    // Floating ctrl with ctrl_valid low is ignored.
    ifa.ctrl_valid = 1'b0;
    ifa.ctrl       = 2'bzz;
    ifa.a          = 'z;
    ifa.b          = 'z;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_valid", ifa.acc_valid, 0);
    end
    chk("idle_acc", ifa.acc, 2);
    chk("idle_cnt", ifa.mac_cnt, 4);
    chk("idle_ovf", ifa.ovf, 0);

    // NOP with ctrl_valid high: no strobe, no change.
    drive_a(1'b1, OP_NOP, 8'sd7, 8'sd7);
    tick();
    drive_a(1'b0, OP_NOP, 8'sd0, 8'sd0);
    tick();
    chk("nop_valid", ifa.acc_valid, 0);
    chk("nop_acc", ifa.acc, 2);

    // CLR followed immediately by MAC 3*3: MAC sees acc=0.
    drive_a(1'b1, OP_CLR, 8'sd0, 8'sd0);
    tick();
    drive_a(1'b1, OP_MAC, 8'sd3, 8'sd3);
    tick();
    drive_a(1'b0, OP_NOP, 8'sd0, 8'sd0);
    chk("clr_acc", ifa.acc, 0);
    chk("clr_valid", ifa.acc_valid, 1);
    chk("clr_cnt", ifa.mac_cnt, 0);
    chk("clr_ovf", ifa.ovf, 0);
    tick();
    chk("after_clr_acc", ifa.acc, 9);
    chk("after_clr_cnt", ifa.mac_cnt, 1);

    // Overflow on the 16-bit accumulator: 16384 + 16384.
    drive_b(1'b1, OP_MUL, -8'sd128, -8'sd128);
    tick();
    drive_b(1'b1, OP_MAC, -8'sd128, -8'sd128);
    tick();
    drive_b(1'b1, OP_NOP, 8'sd0, 8'sd0);
    chk("ovf_mul_acc", ifb.acc, 16384);
    chk("ovf_mul_flag", ifb.ovf, 0);
    tick();
    drive_b(1'b0, OP_NOP, 8'sd0, 8'sd0);
`ifdef MAC_DATAPATH_SAT_EN
    chk("ovf_mac_acc", ifb.acc, 32767);
`else
    chk("ovf_mac_acc", ifb.acc, -32768);
`endif
    chk("ovf_mac_flag", ifb.ovf, 1);
    tick();
    chk("ovf_sticky_nop", ifb.ovf, 1);
    chk("ovf_nop_valid", ifb.acc_valid, 0);

    // Counter saturation: 260 more MACs of 0*0 on top of 2.
    drive_b(1'b1, OP_MAC, 8'sd0, 8'sd0);
    for (int i = 0; i < 260; i++) tick();
    drive_b(1'b0, OP_NOP, 8'sd0, 8'sd0);
    tick();
    tick();
    chk("cnt_sat", ifb.mac_cnt, 255);
    chk("cnt_sat_ovf", ifb.ovf, 1);
    drive_b(1'b1, OP_CLR, 8'sd0, 8'sd0);
    tick();
    drive_b(1'b0, OP_NOP, 8'sd0, 8'sd0);
    tick();
    chk("clrb_acc", ifb.acc, 0);
    chk("clrb_ovf", ifb.ovf, 0);
    chk("clrb_cnt", ifb.mac_cnt, 0);

    // Asynchronous reset between the two edges drops the in-flight MUL.
    drive_a(1'b1, OP_MUL, 8'sd5, 8'sd5);
    tick();
    drive_a(1'b0, OP_NOP, 8'sd0, 8'sd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_acc", ifa.acc, 0);
    chk("arst_cnt", ifa.mac_cnt, 0);
    #1 rst = 1'b0;
    tick();
    chk("arst_lost_acc", ifa.acc, 0);
    chk("arst_lost_valid", ifa.acc_valid, 0);
    tick();
    chk("arst_lost_valid2", ifa.acc_valid, 0);
    chk("arst_lost_cnt", ifa.mac_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_datapath.md
Name: mac_datapath

Overview:
- Two-stage pipelined signed multiply-accumulate datapath.
- Sits directly downstream of the MAC controller and consumes its 2-bit ctrl op code together with operand pair a/b.
- Stage 1 registers the op and the product a*b; stage 2 updates the accumulator.
- Produces the accumulator value, a one-cycle result strobe, a sticky overflow flag and a count of accumulate ops.

Parameters:
- W, 8, operand width (signed two's complement).
- ACC_W, 20, accumulator width; must be >= 2*W.
- CNT_W, 8, width of the MAC-op counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ctrl_valid  input  1  ctrl/a/b are sampled only when high.
- ctrl  input  2  op code: 00 NOP, 01 MUL, 10 MAC, 11 CLR.
- a  input  W  signed operand A.
- b  input  W  signed operand B.
- acc  output  ACC_W  signed accumulator value.
- acc_valid  output  1  one-cycle pulse when acc was updated by MUL/MAC/CLR.
- ovf  output  1  sticky signed-overflow flag.
- mac_cnt  output  CNT_W  number of MUL+MAC ops since last CLR/reset; saturates at all-ones.

Behaviour:
- Reset (rst=1, asynchronous):
  - acc=0, acc_valid=0, ovf=0, mac_cnt=0.
  - Both pipeline stage valids cleared; in-flight ops are dropped, not completed.
- Throughput: one op accepted per cycle; no backpressure, no ready signal.
- Invalid input: ctrl is ignored when ctrl_valid=0, including X/Z values (the controller floats ctrl between strobes). With ctrl_valid=1, op 00 (NOP) behaves as no op.
- Stage 1, at edge N when ctrl_valid=1:
  - Latch op into s1_op.
  - Latch product p = a*b as a signed full 2*W-bit value.
  - Set s1_vld.
- Stage 2, at edge N+1 when s1_vld=1:
  - MUL: acc <= sext(p).
  - MAC: acc <= acc + sext(p).
  - CLR: acc <= 0, ovf <= 0, mac_cnt <= 0.
  - NOP: no change.
  - acc_valid <= 1 for MUL/MAC/CLR, otherwise 0.
- Latency: acc reflects an op 2 rising edges after it is sampled.
- Back-to-back ops:
  - Stage 2 uses its own registered acc, so consecutive MACs chain with no bubble and no forwarding hazard.
  - An op in stage 1 and a CLR in stage 2 in the same cycle: the CLR takes effect first, and the next op sees acc=0.
- Width rule: p is sign-extended to ACC_W. The MAC sum is computed at ACC_W+1 bits.
- Overflow (MAC only):
  - Detected when both addends have the same sign and the result sign differs.
  - On overflow, ovf <= 1; it stays set until CLR or reset.
  - MUL never overflows because ACC_W >= 2*W.
- Counter: mac_cnt increments on each MUL or MAC reaching stage 2 and holds at 2^CNT_W-1.

Optional Feature:
- Macro MAC_DATAPATH_SAT_EN.
- Defined: on a MAC overflow, acc clamps to +(2^(ACC_W-1)-1) on positive overflow or -(2^(ACC_W-1)) on negative overflow, and ovf is set.
- Undefined: acc wraps modulo 2^ACC_W, and ovf is still set.
- All other behaviour is identical in both builds.

Decomposition:
- Package mac_pkg holds:
  - Op-code localparams OP_NOP, OP_MUL, OP_MAC, OP_CLR.
  - A typedef for the 2-bit op.
  - Default width constants.
  - mac_pkg is shared with the controller.
- One sub-module, mac_mul_stage: the registered signed multiplier with valid/op passthrough (stage 1). Stage 2 stays in the top module.

Test Plan:
- MUL a=3,b=4, then idle -> acc=12 with a one-cycle acc_valid pulse 2 edges after sampling; mac_cnt=1.
- Back-to-back MUL 2*3 then MAC 4*5 on consecutive cycles -> acc=6, then acc=26 on the next edge; acc_valid high for 2 cycles; mac_cnt=2.
- MAC a=-2,b=5 after acc=12 -> acc=2. Then CLR -> acc=0, ovf=0, mac_cnt=0, acc_valid pulses.
- ACC_W=16, MUL -128*-128 -> 16384, then MAC -128*-128 ->
  - without SAT_EN: acc=-32768 (0x8000), ovf=1.
  - with SAT_EN: acc=32767, ovf=1.
  - ovf stays 1 after a subsequent NOP.
- ctrl=2'bzz with ctrl_valid=0 for 5 cycles -> acc, ovf and mac_cnt unchanged; acc_valid stays 0.
- MUL issued, rst asserted between the two edges (asynchronously) -> acc=0 immediately; no acc_valid pulse after release; the op is lost.
